// File: rtl/capture_reg_arbiter.sv
// Round-robin arbiter that shares one capture register among NUM_REQ requesters.
// The owner's data word is captured on every edge while its request is held.
// A hold limit forces a handover when others are waiting. Every change of owner
// passes through a one-cycle dead gap.
module capture_reg_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_REQ-1:0]                           req,
  input  logic [NUM_REQ*DATA_W-1:0]                    d,
  output logic [NUM_REQ-1:0]                           gnt,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
  output logic [DATA_W-1:0]                            q,
  output logic                                         q_valid,
  output logic                                         busy,
  output logic [15:0]                                  cap_cnt
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(MAX_HOLD);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [HoldW-1:0]  hold_cnt_q;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand;
  logic [NUM_REQ-1:0] win_mask;
  logic [NUM_REQ-1:0] own_mask;
  logic              other_req;
  logic [IdxW-1:0]   next_ptr;
  logic [DATA_W-1:0] own_data;

  // Pick the first active request starting at rr_ptr and wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_mask  = NUM_REQ'(1) << win_idx;
  assign own_mask  = NUM_REQ'(1) << owner;
  assign other_req = |(req & ~own_mask);
  assign next_ptr  = (owner == LastIdx) ? '0 : owner + 1'b1;
  assign own_data  = d[int'(owner)*int'(DATA_W) +: DATA_W];
  assign busy      = (state_q == StOwn);

  // Arbitration / ownership FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt        <= '0;
      owner      <= '0;
      q          <= '0;
      q_valid    <= 1'b0;
      cap_cnt    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          q_valid <= 1'b0;
          if (win_found) begin
            gnt        <= win_mask;
            owner      <= win_idx;
            hold_cnt_q <= '0;
            state_q    <= StOwn;
          end
        end
        StOwn: begin
          if (req[owner]) begin
            q       <= own_data;
            q_valid <= 1'b1;
            cap_cnt <= cap_cnt + 16'd1;
            if (hold_cnt_q != HoldMax) hold_cnt_q <= hold_cnt_q + 1'b1;
            // >= so an owner already past the limit (held alone) still yields
            // once someone else starts waiting.
            if (hold_cnt_q >= HoldLast && other_req) begin
              gnt      <= '0;
              rr_ptr_q <= next_ptr;
              state_q  <= StGap;
            end
          end else begin
            q_valid  <= 1'b0;
            gnt      <= '0;
            rr_ptr_q <= next_ptr;
            state_q  <= StGap;
          end
        end
        StGap: begin
          q_valid <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          q_valid <= 1'b0;
          gnt     <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_reg_arbiter.sv
// Directed bench for capture_reg_arbiter (NUM_REQ=4, DATA_W=8, MAX_HOLD=4).
module tb_capture_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] d;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;
  logic        busy;
  logic [15:0] cap_cnt;

  int checks = 0;
  int errors = 0;

  capture_reg_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .MAX_HOLD(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .d      (d),
    .gnt    (gnt),
    .owner  (owner),
    .q      (q),
    .q_valid(q_valid),
    .busy   (busy),
    .cap_cnt(cap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    d   = {8'h3C, 8'h5A, 8'hA5, 8'h11};

    // Reset state
    step();
    step();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_owner", owner, 2'd0);
    check("rst_q", q, 8'h00);
    check("rst_qv", q_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", cap_cnt, 16'd0);
    rst = 1'b0;

    // Single requester, 3 captures
    req = 4'b0010;
    step();
    check("single_gnt", gnt, 4'b0010);
    check("single_owner", owner, 2'd1);
    check("single_busy", busy, 1'b1);
    check("single_qv0", q_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("single_q", q, 8'hA5);
      check("single_qv", q_valid, 1'b1);
      check("single_gnt_hold", gnt, 4'b0010);
    end
    check("single_cnt", cap_cnt, 16'd3);
    req = 4'b0000;
    step();
    check("single_gap_gnt", gnt, 4'b0000);
    check("single_gap_busy", busy, 1'b0);
    check("single_gap_qv", q_valid, 1'b0);
    check("single_gap_q", q, 8'hA5);
    check("single_gap_owner", owner, 2'd1);
    check("single_gap_cnt", cap_cnt, 16'd3);
    step();
    check("single_idle_gnt", gnt, 4'b0000);
    check("single_idle_busy", busy, 1'b0);
    // rr_ptr is now 2: of {0,1,3} requester 3 comes first
    req = 4'b1011;
    step();
    check("rrptr_gnt", gnt, 4'b1000);
    check("rrptr_owner", owner, 2'd3);
    req = 4'b0000;
    step();
    check("rrptr_rel_gnt", gnt, 4'b0000);
    check("rrptr_rel_cnt", cap_cnt, 16'd3);
    step();

    // Reset mid-OWN
    req = 4'b0100;
    step();
    check("rmid_gnt", gnt, 4'b0100);
    step();
    check("rmid_q", q, 8'h5A);
    check("rmid_cnt", cap_cnt, 16'd4);
    #2;
    rst = 1'b1;
    #1;
    check("rmid_imm_gnt", gnt, 4'b0000);
    check("rmid_imm_q", q, 8'h00);
    check("rmid_imm_qv", q_valid, 1'b0);
    check("rmid_imm_busy", busy, 1'b0);
    check("rmid_imm_cnt", cap_cnt, 16'd0);
    step();
    check("rmid_edge_q", q, 8'h00);
    check("rmid_edge_gnt", gnt, 4'b0000);
    rst = 1'b0;
    step();
    check("rmid_regrant", gnt, 4'b0100);
    req = 4'b0000;
    step();
    step();

    // Simultaneous requests after reset
    reset_pulse();
    req = 4'b0101;
    step();
    check("sim_first_gnt", gnt, 4'b0001);
    step();
    step();
    check("sim_q0", q, 8'h11);
    check("sim_cnt0", cap_cnt, 16'd2);
    req = 4'b0100;
    step();
    check("sim_gap_gnt", gnt, 4'b0000);
    check("sim_gap_qv", q_valid, 1'b0);
    step();
    check("sim_idle_gnt", gnt, 4'b0000);
    step();
    check("sim_second_gnt", gnt, 4'b0100);
    check("sim_second_owner", owner, 2'd2);
    step();
    step();
    check("sim_q2", q, 8'h5A);
    check("sim_cnt2", cap_cnt, 16'd4);
    req = 4'b0000;
    step();
    step();

    // Hold limit with req[0] and req[3] both held
    reset_pulse();
    req = 4'b1001;
    step();
    check("hold_gnt0", gnt, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      step();
      check("hold_q0", q, 8'h11);
      check("hold_qv0", q_valid, 1'b1);
      check("hold_gnt_own0", gnt, (k < 3) ? 4'b0001 : 4'b0000);
    end
    check("hold_cnt_a", cap_cnt, 16'd4);
    step();
    check("hold_gap1_gnt", gnt, 4'b0000);
    check("hold_gap1_qv", q_valid, 1'b0);
    step();
    check("hold_gnt3", gnt, 4'b1000);
    check("hold_owner3", owner, 2'd3);
    for (int k = 0; k < 4; k++) begin
      step();
      check("hold_q3", q, 8'h3C);
      check("hold_qv3", q_valid, 1'b1);
      check("hold_gnt_own3", gnt, (k < 3) ? 4'b1000 : 4'b0000);
    end
    step();
    check("hold_gap2_gnt", gnt, 4'b0000);
    step();
    check("hold_back_gnt", gnt, 4'b0001);
    check("hold_cnt_b", cap_cnt, 16'd8);

    // Sole requester beyond the limit
    reset_pulse();
    req = 4'b1000;
    step();
    check("sole_gnt", gnt, 4'b1000);
    for (int k = 0; k < 10; k++) begin
      step();
      check("sole_gnt_hold", gnt, 4'b1000);
      check("sole_qv", q_valid, 1'b1);
      check("sole_busy", busy, 1'b1);
    end
    check("sole_cnt", cap_cnt, 16'd10);

    // cap_cnt wrap while the sole owner keeps capturing
    force dut.cap_cnt = 16'hFFFF;
    #1;
    release dut.cap_cnt;
    step();
    check("wrap_cnt", cap_cnt, 16'h0000);
    check("wrap_qv", q_valid, 1'b1);
    check("wrap_q", q, 8'h3C);
    req = 4'b0000;
    step();
    check("wrap_rel_qv", q_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
